c64_dma_loader: RTL

- Expansion-port DMA master that writes a program image into C64 RAM through the cartridge port. It is the write-side counterpart of the cartridge ROM responder.
- Sequence: takes the bus with DMA, waits for BA, then performs one write per phi2 cycle, streaming bytes from a local image memory.
- Sits beside the c64 top in benches and the board top, driving the c64 Ai/Di/RW/DMA inputs.
- Used to inject test programs (e.g. at $0801) without going through the KERNAL loader.

---
 rtl/c64_pkg.sv | 18 +
 rtl/c64_phi2_edge.sv | 31 +++
 rtl/c64_dma_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/c64_pkg.sv
// Shared definitions for C64 expansion-port bus masters.
package c64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_STALL   = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [15:0] BASIC_START = 16'h0801;

endpackage

// File: rtl/c64_phi2_edge.sv
// phi2 falling-edge detector and BA synchroniser for expansion-port masters.
`default_nettype none
module c64_phi2_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phi2,
  input  logic ba,
  output logic phi2_fall,
  output logic ba_s
);

  logic            phi2_q;
  logic [SYNC-1:0] ba_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_q  <= 1'b0;
      ba_sync <= '0;
    end else begin
      phi2_q  <= phi2;
      ba_sync <= (ba_sync << 1) | SYNC'(ba);
    end
  end

  assign phi2_fall = !phi2 && phi2_q;
  assign ba_s      = ba_sync[SYNC-1];

endmodule
`default_nettype wire

// File: rtl/c64_dma_loader.sv
// Expansion-port DMA master: streams an image from local ROM into C64 RAM,
// one write per phi2 cycle while BA allows it.
`default_nettype none
module c64_dma_loader
  import c64_pkg::*;
#(
  parameter int IMG_AW        = 13,
  parameter int PAUSE_BA_SYNC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       load_base,
  input  logic [IMG_AW:0]   load_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              phi2,
  input  logic              BA,
  output logic              DMA,
  output logic              RW,
  output logic [15:0]       Ai,
  output logic [7:0]        Do,
  output logic [IMG_AW-1:0] img_addr,
  input  logic [7:0]        img_data
);

  logic phi2_fall;
  logic ba_s;

  c64_phi2_edge #(
    .SYNC(PAUSE_BA_SYNC)
  ) u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .phi2     (phi2),
    .ba       (BA),
    .phi2_fall(phi2_fall),
    .ba_s     (ba_s)
  );

  state_t          state;
  logic [15:0]     addr;
  logic [IMG_AW:0] cnt;
  logic            fetch_wait;
  logic            abort_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      cnt        <= '0;
      fetch_wait <= 1'b0;
      abort_seen <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      DMA        <= 1'b0;
      RW         <= RW_READ;
      Ai         <= '0;
      Do         <= '0;
      img_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (load_len == '0) begin
              done <= 1'b1;
            end else begin
              addr     <= load_base;
              cnt      <= load_len;
              img_addr <= '0;
              busy     <= 1'b1;
              DMA      <= 1'b1;
              state    <= ST_REQ;
            end
          end
        end

        ST_REQ, ST_STALL: begin
          if (abort) begin
            state <= ST_RELEASE;
          end else if (phi2_fall && ba_s) begin
            fetch_wait <= 1'b1;
            abort_seen <= 1'b0;
            state      <= ST_FETCH;
          end
        end

        // First cycle lets the registered image ROM settle on img_addr.
        ST_FETCH: begin
          if (abort) abort_seen <= 1'b1;
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            Do    <= img_data;
            Ai    <= addr;
            RW    <= RW_WRITE;
            state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (phi2_fall) begin
            RW       <= RW_READ;
            addr     <= addr + 16'd1;
            img_addr <= img_addr + 1'b1;
            cnt      <= cnt - 1'b1;
            if (cnt == (IMG_AW+1)'(1) || abort_seen || abort) begin
              state <= ST_RELEASE;
            end else if (ba_s) begin
              fetch_wait <= 1'b1;
              abort_seen <= 1'b0;
              state      <= ST_FETCH;
            end else begin
              state <= ST_STALL;
            end
          end else if (abort) begin
            abort_seen <= 1'b1;
          end
        end

        ST_RELEASE: begin
          DMA   <= 1'b0;
          RW    <= RW_READ;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
